serial_subtractor: RTL and testbench

//   Bit-serial word subtractor: computes diff = a - b over WIDTH clock cycles, one bit per cycle, LSB first.

---
 rtl/serial_subtractor.sv | 112 +++++++++++
 tb/tb_serial_subtractor.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, one bit per clock, LSB first, using a single full-subtractor cell
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   start           request, accepted only in IDLE or DONE
//   a, b            minuend / subtrahend, captured on an accepted start
//   busy            high while bits are being processed
//   done            one-cycle pulse when diff/borrow_out are updated
//   diff            a - b modulo 2^WIDTH, held until the next result
//   borrow_out      final borrow, 1 iff a < b (unsigned)
//   overflow        signed overflow flag, present only when SERIAL_SUB_OVF_EN is defined
// Optional feature macro: SERIAL_SUB_OVF_EN
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             overflow
`endif
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-2:0] res;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             d;
    logic             bnext;
    logic [WIDTH-1:0] nxt;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb;
    logic             b_msb;
`endif

    assign d     = sa[0] ^ sb[0] ^ br;
    assign bnext = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    // bits already produced sit in res; the new bit enters at the MSB side
    assign nxt   = {d, res};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sa         <= '0;
            sb         <= '0;
            res        <= '0;
            cnt        <= '0;
            br         <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            overflow   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        br    <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    res <= nxt[WIDTH-1:1];
                    br  <= bnext;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        cnt        <= '0;
                        state      <= DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        diff       <= nxt;
                        borrow_out <= bnext;
`ifdef SERIAL_SUB_OVF_EN
                        // signed overflow: operand signs differ and result sign differs from a
                        overflow   <= (a_msb != b_msb) && (d != a_msb);
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: self-checking bench for serial_subtractor (WIDTH=4) against an arithmetic model
module tb_serial_subtractor;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    logic         overflow;
`endif

    int errors = 0;
    int checks = 0;
    int dcnt = 0;
    logic [W-1:0] prev_diff = '0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .a(a),
        .b(b),
        .busy(busy),
        .done(done),
        .diff(diff),
        .borrow_out(borrow_out)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .overflow(overflow)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) dcnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] m_diff(input int x, input int y);
        return W'((x - y) & ((1 << W) - 1));
    endfunction

    function automatic logic m_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
        int sx;
        int sy;
        int sd;
        sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
        sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
        sd = sx - sy;
        return (sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1);
    endfunction

    // Assumes DUT idle and time just after a rising edge.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y);
        int n;
        a = x;
        b = y;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        chk("busy_on", busy, 1);
        chk("diff_held", diff, prev_diff);
        n = 0;
        while (done !== 1'b1 && n < W + 4) begin
            @(posedge clk); #1;
            n++;
            if (done !== 1'b1) begin
                a = W'($urandom);
                b = W'($urandom);
            end
        end
        chk("latency", n, W);
        chk("diff", diff, m_diff(int'(x), int'(y)));
        chk("borrow", borrow_out, (x < y) ? 1 : 0);
`ifdef SERIAL_SUB_OVF_EN
        chk("overflow", overflow, m_ovf(x, y));
`endif
        prev_diff = m_diff(int'(x), int'(y));
        @(posedge clk); #1;
        chk("done_pulse", done, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        int d0;
        int nd;
        int last;
        int cyc;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_diff", diff, 0);
        chk("rst_borrow", borrow_out, 0);
`ifdef SERIAL_SUB_OVF_EN
        chk("rst_ovf", overflow, 0);
`endif
        run_op(4'd5, 4'd3);
        run_op(4'd3, 4'd5);
        run_op(4'd0, 4'd0);
        run_op(4'd0, 4'd1);
        run_op(4'd8, 4'd1);
        run_op(4'd7, 4'd1);

        // start held high: back-to-back ops, operands scrambled while busy
        a = 4'd9;
        b = 4'd2;
        start = 1'b1;
        nd = 0;
        last = -1;
        cyc = 0;
        while (nd < 3 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (busy === 1'b1) begin
                a = W'($urandom);
                b = W'($urandom);
            end else begin
                a = 4'd9;
                b = 4'd2;
            end
            if (done === 1'b1) begin
                chk("b2b_diff", diff, 7);
                chk("b2b_borrow", borrow_out, 0);
                if (last >= 0) chk("b2b_period", cyc - last, W + 1);
                last = cyc;
                nd++;
            end
        end
        chk("b2b_count", nd, 3);
        start = 1'b0;
        @(posedge clk); #1;
        prev_diff = 4'd7;
        chk("b2b_idle", busy, 0);

        // reset in the second SHIFT cycle aborts the operation
        run_op(4'd3, 4'd5);
        a = 4'd6;
        b = 4'd1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_diff", diff, 0);
        chk("abort_borrow", borrow_out, 0);
        d0 = dcnt;
        repeat (W + 2) @(posedge clk);
        #1;
        chk("abort_nodone", dcnt - d0, 0);
        prev_diff = '0;
        run_op(4'd15, 4'd1);

        for (int i = 0; i < 20; i++) run_op(W'($urandom), W'($urandom));

        d0 = dcnt;
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                run_op(W'(x), W'(y));
        chk("exh_done_count", dcnt - d0, 256);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
